traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Sequences the lab board's jumbo R/Y/G LED as a timed traffic light with a pedestrian "walk" request from pushbutton S1, and exposes the remaining-seconds count for display on a seven-segment digit. Sits between the board-level active-low pin inversion layer and the jumbo, yellow and seven-segment drivers. Green duration and maintenance (flashing-red) mode come from the DIP switches. All ports here are active-high; the top level does the pin inversion.

## Interface
- `TICK_DIV`, default 1000: number of `i_clk` cycles per one-second tick (range 2..65535).
- `YEL_SECS`, default 3: yellow duration in seconds (range 1..15).
- `RED_SECS`, default 5: red/walk duration in seconds (range 1..15).

Clock and reset: one clock; reset is synchronous and active-high.
- `i_clk` input 1: system clock.
- `i_rst` input 1: synchronous, active-high reset.
- `i_dip` input 8: `[7]` = run (1) / flash maintenance (0); `[3:0]` = green seconds; `[6:4]` unused.
- `i_s1_nc` input 1: S1 normally-closed contact, already un-inverted.
- `i_s1_no` input 1: S1 normally-open contact, already un-inverted.
- `o_red` output 1: jumbo red.
- `o_yel` output 1: jumbo yellow.
- `o_grn` output 1: jumbo green.
- `o_walk` output 1: walk indicator, driven to the left small yellow LED.
- `o_req_pending` output 1: a pedestrian request is latched and not yet served.
- `o_count` output 4: remaining whole seconds in the current state; 0 in FLASH.
- `o_state` output 2: current state encoding.

## Operation
- States: `RED`=0, `GREEN`=1, `YELLOW`=2, `FLASH`=3.
- Normal order is RED → GREEN → YELLOW → RED.
- `i_dip` passes through a 2-flop synchronizer. All logic uses the synchronized value `dip_s`.
- S1 debounce:
  - 2-flop synchronizer on both contacts, then an SR flop.
  - The SR flop sets on no=1, nc=0 and clears on nc=1, no=0.
  - Both contacts equal means hold, so bounce produces no extra edges.
  - A rising edge of the debounced level is the request event.
- Tick counter counts 0..`TICK_DIV`-1. The tick pulse fires at `TICK_DIV`-1.
  - The counter clears on reset and on every state change, so each state lasts exactly duration×`TICK_DIV` cycles.
- On a tick, a non-FLASH state decrements `o_count`.
  - If `o_count`==1 at the tick, the block transitions instead and loads the next duration.
  - Durations: GREEN = `dip_s[3:0]`, with 0 treated as 1. YELLOW = `YEL_SECS`. RED = `RED_SECS`.
- Pedestrian request handling:
  - A request event sets `o_req_pending` when the state is GREEN or YELLOW.
  - In RED or FLASH the event is discarded.
  - While in GREEN with `o_req_pending`=1 and `o_count`>2, the next cycle sets `o_count`:=2. This overrides a decrement tick in the same cycle.
  - If `o_count`≤2, the count is unchanged.
  - `o_req_pending` clears on entry to RED.
- `o_walk` = 1 exactly while the state is RED.
- FLASH mode:
  - `dip_s[7]`=0 forces FLASH on the next edge from any state. Pending is cleared and the tick counter is cleared.
  - In FLASH, `o_red` toggles on every tick, starting at 1. Yellow, green and walk are 0 and `o_count`=0.
  - `dip_s[7]` returning to 1 forces RED, with `o_count`=`RED_SECS` and the tick counter cleared.
- Outputs are decoded from registered state. There is no combinational path from inputs to outputs.

## Timing
- Reset: at the edge where `i_rst`=1 the block enters:
  - state RED, `o_red`=1, `o_walk`=1;
  - `o_yel`=`o_grn`=0, `o_req_pending`=0;
  - `o_count`=`RED_SECS`, `o_state`=0;
  - tick counter 0, synchronizers and SR flop 0.
- Reset applied mid-state has the same result; no partial state survives.
- S1 latency: contacts change before edge N, then `o_req_pending`=1 after edge N+3. Shortening of `o_count` is visible after edge N+4.
- DIP latency: `i_dip` change before edge N, then `dip_s` is valid after N+1 and the state effect (FLASH/RED) is visible after N+2.
- Green duration is sampled on entry to GREEN. DIP changes during GREEN do not alter the current green.
- A request event coinciding with the GREEN→YELLOW edge is latched and served by the following RED.

## Structure
- Package `traffic_pkg`:
  - state typedef and encodings;
  - count width (4);
  - `TICK_W` = `$clog2(TICK_DIV)` helper constants.
- Sub-module `btn_debounce`: 2-flop synchronizers plus NC/NO SR flop plus rising-edge pulse output. It is reusable for S2.
- Tick generator, state machine and output decode stay in `traffic_light_ctrl`.

## Test plan
All scenarios use `TICK_DIV`=4, `YEL_SECS`=3, `RED_SECS`=5.
1. Reset, `i_dip`=8'h86:
   - Expect RED with count 5 and walk=1.
   - GREEN entered after 20 cycles with `o_count`=6.
   - YELLOW 24 cycles later, RED 12 cycles after that.
2. Pedestrian request mid-GREEN:
   - Press S1 (no=1, nc=0) at GREEN `o_count`=6, then `o_req_pending`=1 after 3 edges and `o_count`=2 on the next edge.
   - YELLOW follows ≤8 cycles later.
   - Pending clears on RED entry and walk=1.
3. Bounce:
   - Toggle nc/no through both-0 and both-1 glitches during one press, then exactly one request event.
   - A press during RED leaves `o_req_pending` at 0.
4. Maintenance mode:
   - Set `i_dip[7]`=0 mid-YELLOW, then FLASH after 2 edges with `o_red` toggling every 4 cycles and `o_count`=0.
   - Restore `i_dip[7]`=1, then RED with count 5.
5. Zero green setting: `i_dip[3:0]`=0, then GREEN lasts exactly 4 cycles.
6. Reset mid-YELLOW with a pending request: after one edge, RED, count 5 and `o_req_pending`=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package traffic_pkg;

    // State encodings are visible on o_state, so the values are fixed.
    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_FLASH  = 2'd3
    } state_t;

    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    // Width of the divider counter; never below one bit.
    function automatic int tick_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// NC/NO pushbutton debouncer: 2-flop synchronizers, SR latch, rising-edge pulse.
// Latency: contact change before edge N gives o_rise high after edge N+2 for one cycle.
// Backpressure: none; o_rise is a single-cycle event with no handshake.
//
// Ports: i_clk/i_rst (sync, active-high), i_nc/i_no (un-inverted contacts),
//        o_rise (one-cycle pulse on each debounced press).
module btn_debounce (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_nc,
    input  logic i_no,
    output logic o_rise
);

    logic nc_meta_q, nc_s_q;
    logic no_meta_q, no_s_q;
    logic level_q, level_d;
    logic level_prev_q;

    // A break-before-make switch only sets or clears on an unambiguous
    // contact pair; both-equal (mid-travel or bounce) holds the level.
    always_comb begin
        level_d = level_q;
        if (no_s_q && !nc_s_q) begin
            level_d = 1'b1;
        end else if (nc_s_q && !no_s_q) begin
            level_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            nc_meta_q    <= 1'b0;
            nc_s_q       <= 1'b0;
            no_meta_q    <= 1'b0;
            no_s_q       <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            nc_meta_q    <= i_nc;
            nc_s_q       <= nc_meta_q;
            no_meta_q    <= i_no;
            no_s_q       <= no_meta_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    assign o_rise = level_q && !level_prev_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Timed R/Y/G traffic light with pedestrian request and flashing-red maintenance mode.
// Latency: S1 press -> pending after 4 edges; DIP change -> state effect after 3 edges.
// Backpressure: none; free-running timed sequencer, outputs decoded from registers.
//
// Ports: i_clk/i_rst (sync, active-high); i_dip[7]=run, i_dip[3:0]=green seconds;
//        i_s1_nc/i_s1_no S1 contacts; o_red/o_yel/o_grn lamps; o_walk; o_req_pending;
//        o_count remaining seconds (0 in FLASH); o_state current state encoding.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int YEL_SECS = 3,
    parameter int RED_SECS = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_dip,
    input  logic             i_s1_nc,
    input  logic             i_s1_no,
    output logic             o_red,
    output logic             o_yel,
    output logic             o_grn,
    output logic             o_walk,
    output logic             o_req_pending,
    output logic [3:0]       o_count,
    output logic [1:0]       o_state
);

    localparam int TICK_W = tick_width(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  RED_CNT   = CNT_W'(RED_SECS);
    localparam logic [CNT_W-1:0]  YEL_CNT   = CNT_W'(YEL_SECS);

    logic [7:0]        dip_meta_q, dip_s_q;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              pend_q, pend_d;
    logic              flash_red_q, flash_red_d;
    logic              tick;
    logic              req_evt;
    logic [CNT_W-1:0]  green_cnt;
    logic              unused_dip;

    assign unused_dip = ^dip_s_q[6:4];

    btn_debounce u_s1 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_nc   (i_s1_nc),
        .i_no   (i_s1_no),
        .o_rise (req_evt)
    );

    assign tick      = (tick_cnt_q == TICK_LAST);
    // A zero green setting would otherwise never expire; run it as one second.
    assign green_cnt = (dip_s_q[3:0] == 4'd0) ? CNT_ONE : dip_s_q[3:0];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pend_d      = pend_q;
        flash_red_d = flash_red_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TICK_W'(1);

        if (!dip_s_q[7]) begin
            if (state_q != ST_FLASH) begin
                state_d     = ST_FLASH;
                count_d     = '0;
                pend_d      = 1'b0;
                flash_red_d = 1'b1;
                tick_cnt_d  = '0;
            end else if (tick) begin
                flash_red_d = !flash_red_q;
            end
        end else if (state_q == ST_FLASH) begin
            state_d    = ST_RED;
            count_d    = RED_CNT;
            tick_cnt_d = '0;
        end else begin
            if (req_evt && (state_q == ST_GREEN || state_q == ST_YELLOW)) begin
                pend_d = 1'b1;
            end
            // Shortening takes priority over a same-cycle second tick.
            if (state_q == ST_GREEN && pend_q && count_q > CNT_TWO) begin
                count_d = CNT_TWO;
            end else if (tick) begin
                if (count_q == CNT_ONE) begin
                    tick_cnt_d = '0;
                    case (state_q)
                        ST_RED: begin
                            state_d = ST_GREEN;
                            count_d = green_cnt;
                        end
                        ST_GREEN: begin
                            state_d = ST_YELLOW;
                            count_d = YEL_CNT;
                        end
                        ST_YELLOW: begin
                            // Entering RED serves the request; later
                            // set attempts in this cycle are dropped.
                            state_d = ST_RED;
                            count_d = RED_CNT;
                            pend_d  = 1'b0;
                        end
                        default: begin
                            state_d = state_q;
                        end
                    endcase
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dip_meta_q  <= '0;
            dip_s_q     <= '0;
            state_q     <= ST_RED;
            count_q     <= RED_CNT;
            tick_cnt_q  <= '0;
            pend_q      <= 1'b0;
            flash_red_q <= 1'b1;
        end else begin
            dip_meta_q  <= i_dip;
            dip_s_q     <= dip_meta_q;
            state_q     <= state_d;
            count_q     <= count_d;
            tick_cnt_q  <= tick_cnt_d;
            pend_q      <= pend_d;
            flash_red_q <= flash_red_d;
        end
    end

    assign o_red         = (state_q == ST_RED) || (state_q == ST_FLASH && flash_red_q);
    assign o_yel         = (state_q == ST_YELLOW);
    assign o_grn         = (state_q == ST_GREEN);
    assign o_walk        = (state_q == ST_RED);
    assign o_req_pending = pend_q;
    assign o_count       = count_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl with a reference model and directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_traffic_light_ctrl;

    localparam int TD = 4;
    localparam int YS = 3;
    localparam int RS = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dip;
    logic       nc, no;
    logic       o_red, o_yel, o_grn, o_walk, o_req_pending;
    logic [3:0] o_count;
    logic [1:0] o_state;

    traffic_light_ctrl #(.TICK_DIV(TD), .YEL_SECS(YS), .RED_SECS(RS)) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_dip         (dip),
        .i_s1_nc       (nc),
        .i_s1_no       (no),
        .o_red         (o_red),
        .o_yel         (o_yel),
        .o_grn         (o_grn),
        .o_walk        (o_walk),
        .o_req_pending (o_req_pending),
        .o_count       (o_count),
        .o_state       (o_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rise_cnt = 0;
    bit rise_en = 1'b0;

    // Reference model: light phase, seconds left, cycles into current second.
    int         m_state;     // 0 red, 1 green, 2 yellow, 3 flash
    int         m_secs;
    int         m_phase;
    bit         m_pend;
    bit         m_flash_on;
    logic [7:0] dip_p0, dip_p1;   // i_dip one and two edges back
    logic [1:0] ct_p0, ct_p1;     // {nc,no} one and two edges back
    bit         lvl, lvl_prev;

    always @(posedge clk) begin
        logic [7:0] seen;
        bit ev, end_sec, changed, old_pend;
        int g;
        if (rst) begin
            m_state = 0; m_secs = RS; m_phase = 0; m_pend = 0; m_flash_on = 1;
            dip_p0 = '0; dip_p1 = '0; ct_p0 = '0; ct_p1 = '0;
            lvl = 0; lvl_prev = 0;
        end else begin
            seen    = dip_p1;
            ev      = lvl && !lvl_prev;
            end_sec = (m_phase == TD - 1);
            changed = 0;
            if (!seen[7]) begin
                if (m_state != 3) begin
                    m_state = 3; changed = 1; m_pend = 0; m_flash_on = 1;
                end else if (end_sec) begin
                    m_flash_on = !m_flash_on;
                end
            end else if (m_state == 3) begin
                m_state = 0; m_secs = RS; changed = 1;
            end else begin
                old_pend = m_pend;
                if (ev && (m_state == 1 || m_state == 2)) m_pend = 1;
                if (m_state == 1 && old_pend && m_secs > 2) begin
                    m_secs = 2;
                end else if (end_sec) begin
                    if (m_secs == 1) begin
                        changed = 1;
                        if (m_state == 0) begin
                            g = int'(seen[3:0]);
                            m_state = 1; m_secs = (g == 0) ? 1 : g;
                        end else if (m_state == 1) begin
                            m_state = 2; m_secs = YS;
                        end else begin
                            m_state = 0; m_secs = RS; m_pend = 0;
                        end
                    end else begin
                        m_secs = m_secs - 1;
                    end
                end
            end
            m_phase = (changed || end_sec) ? 0 : m_phase + 1;
            // Button: SR on contacts seen through two flops.
            lvl_prev = lvl;
            if (ct_p1[0] && !ct_p1[1]) lvl = 1;
            else if (ct_p1[1] && !ct_p1[0]) lvl = 0;
            ct_p1 = ct_p0; ct_p0 = {nc, no};
            dip_p1 = dip_p0; dip_p0 = dip;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance n edges, sampling 1 time unit after each edge and comparing to the model.
    task automatic step(input int n);
        logic [10:0] act, exp;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rise_en && u_dut.u_s1.o_rise) rise_cnt++;
            exp = {(m_state == 0) || (m_state == 3 && m_flash_on), m_state == 2, m_state == 1,
                   m_state == 0, m_pend, (m_state == 3) ? 4'd0 : 4'(m_secs), 2'(m_state)};
            act = {o_red, o_yel, o_grn, o_walk, o_req_pending, o_count, o_state};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model_cmp t=%0t got r%b y%b g%b w%b p%b c%0d s%0d expected r%b y%b g%b w%b p%b c%0d s%0d",
                         $time, act[10], act[9], act[8], act[7], act[6], act[5:2], act[1:0],
                         exp[10], exp[9], exp[8], exp[7], exp[6], exp[5:2], exp[1:0]);
            end
        end
    endtask

    task automatic wait_state(input int st, input int max, output int n);
        n = 0;
        while (int'(o_state) != st && n < max) begin
            step(1);
            n++;
        end
        if (int'(o_state) != st) begin
            checks++;
            errors++;
            $display("FAIL wait_state: got state %0d expected %0d within %0d cycles", o_state, st, max);
        end
    endtask

    logic [1:0] press_seq [8];
    logic [1:0] rel_seq   [5];
    int n;

    initial begin
        // {nc,no}: bounce with both-0 and both-1 glitches
        press_seq = '{2'b01, 2'b00, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01, 2'b01};
        rel_seq   = '{2'b10, 2'b00, 2'b11, 2'b10, 2'b10};

        rst = 1'b1; dip = 8'h86; nc = 1'b1; no = 1'b0;
        step(2);
        // 1. reset state
        chk("rst_state", o_state, 0);
        chk("rst_count", o_count, 5);
        chk("rst_walk", o_walk, 1);
        chk("rst_red", o_red, 1);
        chk("rst_pend", o_req_pending, 0);
        rst = 1'b0;
        // synchronized DIP still reads 0 right after reset -> brief FLASH
        step(1);
        chk("post_rst_flash", o_state, 3);
        wait_state(0, 10, n);
        chk("flash_to_red_cycles", n, 2);
        wait_state(1, 40, n);
        chk("red_len", n, 20);
        chk("green_count", o_count, 6);
        wait_state(2, 40, n);
        chk("green_len", n, 24);
        chk("yel_count", o_count, 3);
        wait_state(0, 40, n);
        chk("yel_len", n, 12);

        // 2. pedestrian request mid-GREEN
        wait_state(1, 40, n);
        nc = 1'b0; no = 1'b1;
        step(3);
        chk("req_pend_early", o_req_pending, 0);
        step(1);
        chk("req_pend", o_req_pending, 1);
        chk("req_count_tick", o_count, 5);
        step(1);
        chk("req_shorten", o_count, 2);
        nc = 1'b1; no = 1'b0;
        wait_state(2, 20, n);
        chk("req_to_yel", n, 7);
        wait_state(0, 20, n);
        chk("req_red_pend", o_req_pending, 0);
        chk("req_red_walk", o_walk, 1);

        // 3. bounce: exactly one event; press in RED discarded
        wait_state(1, 40, n);
        rise_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {nc, no} = press_seq[i];
            step(1);
        end
        for (int i = 0; i < 5; i++) begin
            {nc, no} = rel_seq[i];
            step(1);
        end
        step(4);
        rise_en = 1'b0;
        chk("bounce_events", rise_cnt, 1);
        wait_state(0, 30, n);
        nc = 1'b0; no = 1'b1;
        step(6);
        nc = 1'b1; no = 1'b0;
        step(6);
        chk("red_press_pend", o_req_pending, 0);
        chk("red_press_state", o_state, 0);

        // 4. maintenance mode
        wait_state(1, 40, n);
        wait_state(2, 40, n);
        chk("maint_green_len", n, 24);
        step(4);
        dip = 8'h06;
        step(2);
        chk("maint_still_yel", o_state, 2);
        step(1);
        chk("maint_flash", o_state, 3);
        chk("maint_count", o_count, 0);
        chk("maint_red_on", o_red, 1);
        chk("maint_yel_off", o_yel, 0);
        step(3);
        chk("flash_hold1", o_red, 1);
        step(1);
        chk("flash_toggle0", o_red, 0);
        step(3);
        chk("flash_hold0", o_red, 0);
        step(1);
        chk("flash_toggle1", o_red, 1);
        dip = 8'h86;
        step(2);
        chk("restore_still_flash", o_state, 3);
        step(1);
        chk("restore_red", o_state, 0);
        chk("restore_count", o_count, 5);

        // 5. zero green setting
        dip = 8'h80;
        wait_state(1, 40, n);
        chk("zero_green_count", o_count, 1);
        wait_state(2, 40, n);
        chk("zero_green_len", n, 4);

        // 6. reset mid-YELLOW with pending request
        nc = 1'b0; no = 1'b1;
        step(5);
        chk("yel_pend", o_req_pending, 1);
        chk("yel_state", o_state, 2);
        rst = 1'b1; nc = 1'b1; no = 1'b0; dip = 8'h86;
        step(1);
        chk("midrst_state", o_state, 0);
        chk("midrst_count", o_count, 5);
        chk("midrst_pend", o_req_pending, 0);
        chk("midrst_yel", o_yel, 0);
        rst = 1'b0;
        step(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
